// File: rtl/alu_mc_if.sv
// alu_mc request/response bundle: operand request channel, result channel and status.
// The master drives requests and out_ready; the slave returns handshake, result and flags.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, carry, negative, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, carry, negative, overflow, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU (MUL datapath only with ALU_MC_MUL_EN): 1 cycle, shifts b[SHW-1:0] cycles, MUL WIDTH cycles.
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);
  localparam int CW = (SHW + 1 > $clog2(WIDTH) + 1) ? SHW + 1 : $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7;
  localparam logic [3:0] OP_EQ  = 4'h8, OP_GT  = 4'h9, OP_SRA = 4'hA;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] res_q, sc_res, sh_res;
  logic             zero_q, carry_q, neg_q, ovf_q;
  logic             sc_c, sc_v, sh_c;
  logic [WIDTH:0]   sum, diff;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [SHW-1:0]   amt;
  logic             accept, is_shift, go_exec;

  assign accept   = bus.in_valid && (state == IDLE);
  assign amt      = bus.b[SHW-1:0];
  assign is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_SRA);

`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hB;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic               is_mul;
  assign is_mul   = (bus.op == OP_MUL);
  assign go_exec  = (is_shift && (amt != '0)) || is_mul;
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
`else
  assign go_exec  = is_shift && (amt != '0);
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == EXEC);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.negative  = neg_q;
  assign bus.overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_exec ? EXEC : DONE;
      EXEC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle results; shift ops load the unshifted operand here (covers amount 0).
  always_comb begin
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    diff   = {1'b0, bus.a} - {1'b0, bus.b};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:                 sc_res = bus.a & bus.b;
      OP_OR:                  sc_res = bus.a | bus.b;
      OP_XOR:                 sc_res = bus.a ^ bus.b;
      OP_NOT:                 sc_res = ~bus.a;
      OP_SHL, OP_SHR, OP_SRA: sc_res = bus.a;
      OP_EQ:                  sc_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_GT:                  sc_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
      default:                sc_res = '0;
    endcase
  end

  always_comb begin
    sh_res = res_q;
    sh_c   = 1'b0;
    case (op_q)
      OP_SHL:  begin sh_res = {res_q[WIDTH-2:0], 1'b0};        sh_c = res_q[WIDTH-1]; end
      OP_SHR:  begin sh_res = {1'b0, res_q[WIDTH-1:1]};        sh_c = res_q[0];       end
      OP_SRA:  begin sh_res = {res_q[WIDTH-1], res_q[WIDTH-1:1]}; sh_c = res_q[0];    end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
      op_q    <= '0;
`ifdef ALU_MC_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
`endif
    end else if (accept) begin
      op_q    <= bus.op;
      cnt     <= CW'(amt);
      res_q   <= sc_res;
      zero_q  <= (sc_res == '0);
      carry_q <= sc_c;
      neg_q   <= sc_res[WIDTH-1];
      ovf_q   <= sc_v;
`ifdef ALU_MC_MUL_EN
      if (is_mul) cnt <= CW'(WIDTH);
      mcand   <= {{WIDTH{1'b0}}, bus.a};
      mplier  <= bus.b;
      prod    <= '0;
`endif
    end else if (state == EXEC) begin
      cnt   <= cnt - CW'(1);
      ovf_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
      if (op_q == OP_MUL) begin
        prod    <= prod_nxt;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        res_q   <= prod_nxt[WIDTH-1:0];
        carry_q <= |prod_nxt[2*WIDTH-1:WIDTH];
        zero_q  <= (prod_nxt[WIDTH-1:0] == '0);
        neg_q   <= prod_nxt[WIDTH-1];
      end else begin
`else
      begin
`endif
        res_q   <= sh_res;
        carry_q <= sh_c;
        zero_q  <= (sh_res == '0);
        neg_q   <= sh_res[WIDTH-1];
      end
    end
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width, legal range 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a, b  input  WIDTH each  operands, unsigned unless stated.
REQ-008 op  input  4  operation select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero, carry, negative, overflow  output  1 each  registered flags.
REQ-013 busy  output  1  high in EXEC state.

Function
REQ-014 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL, 7 SHR logical, 8 EQ, 9 GT unsigned, A SRA arithmetic, B MUL; C-F illegal.
REQ-015 FSM states IDLE, EXEC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Handshake: request accepted when in_valid && in_ready; a, b and op are captured on accept and not sampled again.
REQ-017 Single-cycle ops (0-5, 8, 9, illegal): IDLE -> DONE on accept; out_valid asserts the cycle after accept.
REQ-018 Shifts (6, 7, A): shift 1 bit per cycle in EXEC for b[SHW-1:0] cycles, then DONE; shift amount 0 goes IDLE -> DONE directly.
REQ-019 MUL: shift-add, exactly WIDTH EXEC cycles, then DONE; result = low WIDTH bits of a*b.
REQ-020 DONE holds result and flags stable until out_ready; on out_valid && out_ready -> IDLE; no new request is accepted in that same cycle.
REQ-021 ADD: carry = bit WIDTH of a+b; overflow = signed overflow.
REQ-022 SUB: carry = borrow (1 when a<b unsigned); overflow = signed overflow of a-b.
REQ-023 Shifts: carry = last bit shifted out, 0 for shift amount 0; SRA replicates a[WIDTH-1].
REQ-024 MUL: carry = 1 when the high WIDTH bits of the full product are nonzero.
REQ-025 EQ/GT: result = 1 or 0 zero-extended to WIDTH.
REQ-026 carry and overflow = 0 for every op not listed above; overflow = 0 for all except ADD/SUB.
REQ-027 zero = (result==0); negative = result[WIDTH-1], for every op.
REQ-028 Illegal opcode: result = 0, zero = 1, remaining flags 0.

Reset
REQ-029 rst_n low at a rising edge: state = IDLE; result = 0; all flags 0; out_valid = 0; busy = 0; in_ready = 1 from the first cycle after reset.
REQ-030 Reset in EXEC or DONE aborts the operation; no result is delivered for the aborted request.

Configuration
REQ-031 Macro ALU_MC_MUL_EN defined: MUL implemented per REQ-019 and REQ-024.
REQ-032 Macro ALU_MC_MUL_EN undefined: opcode B is illegal per REQ-028 and takes the single-cycle path; no multiplier datapath is synthesised.

Verification (WIDTH=16)
REQ-033 ADD a=FFFF, b=0001 -> one cycle after accept: result=0000, zero=1, carry=1, overflow=0.
REQ-034 SUB a=0003, b=0005 -> result=FFFE, carry=1, negative=1; ADD a=7FFF, b=0001 -> result=8000, overflow=1.
REQ-035 SRA a=8000, b=0004 -> busy for 4 cycles, then result=F800, negative=1, carry=0; SHL with b=0 -> latency 1, result=a, carry=0.
REQ-036 MUL a=0100, b=0100 with ALU_MC_MUL_EN -> out_valid after 16 EXEC cycles, result=0000, zero=1, carry=1; without the macro -> latency 1, result=0000, zero=1.
REQ-037 out_ready held low 5 cycles in DONE -> result and flags stable, in_ready=0 and new requests ignored; out_ready=1 -> IDLE next cycle.
REQ-038 rst_n pulsed low mid-MUL -> out_valid never asserts for that request, all outputs 0, in_ready=1 on the next cycle.
